// File: rtl/uart_tx_echo.sv
// rtl/uart_tx_echo.sv - 8N1 serial transmitter that accepts received bytes via a done/accept handshake
module uart_tx_echo #(
  parameter int clk_frequency = 27,
  parameter int baud_rate     = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_data_valid,
  input  logic [7:0] i_data_byte,
  output logic       o_byte_accept,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int          clk_cycle = (clk_frequency * 1000000) / baud_rate;
  localparam logic [15:0] cnt_max   = 16'(clk_cycle - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        tx_n, busy_n, accept_n, done_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      o_tx          <= 1'b1;
      o_busy        <= 1'b0;
      o_byte_accept <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      shift         <= shift_n;
      o_tx          <= tx_n;
      o_busy        <= busy_n;
      o_byte_accept <= accept_n;
      o_done        <= done_n;
    end
  end

  // Every output is computed one cycle ahead so the line level changes on the
  // same edge as the state that owns it, e.g. the start bit with the accept.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    tx_n     = o_tx;
    busy_n   = o_busy;
    accept_n = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        cnt_n  = '0;
        idx_n  = '0;
        if (i_data_valid) begin
          shift_n  = i_data_byte;
          accept_n = 1'b1;
          busy_n   = 1'b1;
          tx_n     = 1'b0;
          state_n  = START;
        end
      end
      START: begin
        if (cnt == cnt_max) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shift[0];
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == cnt_max) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shift[idx_n];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (cnt == cnt_max) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
